demux_dispatcher: RTL and testbench

Sequencing controller for the 1x2 demux datapath. It accepts a single valid/ready input stream and registers each beat in a one-entry holding buffer. It chooses a destination by round-robin or explicit steering, then presents the beat on exactly one of two output channels until that channel accepts it. The top level places it between a producer and two consumers that share the producer's stream, so it acts as the demux's select/enable sequencer.

---
 rtl/demux_dispatcher_pkg.sv | 12 +
 rtl/demux_dispatcher_beat_counter.sv | 33 +++
 rtl/demux_dispatcher.sv | 121 ++++++++++++
 tb/tb_demux_dispatcher.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_dispatcher_pkg.sv
// Shared types and constants for the 1x2 demux dispatcher.
package demux_dispatcher_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_STEER = 1'b1;

endpackage

// File: rtl/demux_dispatcher_beat_counter.sv
// Wrapping per-port delivered-beat counter.
module beat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/demux_dispatcher.sv
// Select/enable sequencer for a 1x2 demux: one-entry holding buffer, round-robin
// or steered destination, timeout redirect in round-robin mode.
module demux_dispatcher
    import demux_dispatcher_pkg::*;
#(
    parameter int W       = 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic             in_dest,
    output logic             in_ready,
    output logic             y0_valid,
    output logic             y1_valid,
    output logic [W-1:0]     y0_data,
    output logic [W-1:0]     y1_data,
    input  logic             y0_ready,
    input  logic             y1_ready,
    output logic             sel,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit REDIRECT_EN = (TIMEOUT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e              state_q, state_d;
    logic                sel_q, sel_d;
    logic                rr_q, rr_d;
    logic                mode_q, mode_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [W-1:0]        buf_q, buf_d;

    logic hold, sel_ready, accept, deliver, rr_next;

    assign hold      = (state_q == HOLD);
    assign sel_ready = sel_q ? y1_ready : y0_ready;
    // rst_n gates in_ready so nothing looks acceptable while reset is held.
    assign in_ready  = rst_n & en & (~hold | sel_ready);
    assign accept    = in_valid & in_ready;
    assign deliver   = hold & sel_ready;
    // A beat accepted on a delivery edge must see the already-advanced pointer.
    assign rr_next   = deliver ? ~sel_q : rr_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        mode_d  = mode_q;
        wait_d  = wait_q;
        buf_d   = buf_q;
        if (deliver) begin
            rr_d    = ~sel_q;
            state_d = IDLE;
        end else if (hold && (mode_q == MODE_RR) && REDIRECT_EN) begin
            if (wait_q == WAIT_LAST) begin
                sel_d  = ~sel_q;
                wait_d = '0;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
        if (accept) begin
            buf_d   = in_data;
            mode_d  = mode;
            sel_d   = (mode == MODE_STEER) ? in_dest : rr_next;
            wait_d  = '0;
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
            mode_q  <= MODE_RR;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            mode_q  <= mode_d;
            wait_q  <= wait_d;
        end
    end

    // Payload is qualified by state, so it needs no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign y0_valid = hold & ~sel_q;
    assign y1_valid = hold &  sel_q;
    assign y0_data  = y0_valid ? buf_q : '0;
    assign y1_data  = y1_valid ? buf_q : '0;
    assign sel      = sel_q;

    beat_counter #(.CNT_W(CNT_W)) u_cnt0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (deliver & ~sel_q),
        .clr_i   (1'b0),
        .count_o (cnt0)
    );

    beat_counter #(.CNT_W(CNT_W)) u_cnt1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (deliver & sel_q),
        .clr_i   (1'b0),
        .count_o (cnt1)
    );

endmodule

// File: tb/tb_demux_dispatcher.sv
// Bench for demux_dispatcher: transaction-level model checked every cycle plus literal checkpoints.
module tb_demux_dispatcher;

    localparam int W = 8;
    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         rst_n, en, mode, in_valid, in_dest, y0r, y1r;
    logic [W-1:0] in_data;

    logic         in_ready, y0_valid, y1_valid, sel;
    logic [W-1:0] y0_data, y1_data;
    logic [15:0]  cnt0, cnt1;

    logic         w_in_ready, w_y0_valid, w_y1_valid, w_sel;
    logic [W-1:0] w_y0_data, w_y1_data;
    logic [3:0]   w_cnt0, w_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    demux_dispatcher #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest), .in_ready(in_ready),
        .y0_valid(y0_valid), .y1_valid(y1_valid), .y0_data(y0_data), .y1_data(y1_data),
        .y0_ready(y0r), .y1_ready(y1r), .sel(sel), .cnt0(cnt0), .cnt1(cnt1)
    );

    demux_dispatcher #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest), .in_ready(w_in_ready),
        .y0_valid(w_y0_valid), .y1_valid(w_y1_valid), .y0_data(w_y0_data), .y1_data(w_y1_data),
        .y0_ready(y0r), .y1_ready(y1r), .sel(w_sel), .cnt0(w_cnt0), .cnt1(w_cnt1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the slot holds at most one beat; it leaves when its port is ready,
    // and a stalled round-robin beat swaps ports after TIMEOUT waiting cycles.
    bit       m_full, m_port, m_mode, m_rr;
    bit [7:0] m_data;
    int       m_wait, m_cnt0, m_cnt1;
    logic [8:0] log_q[$];

    function automatic bit model_ready();
        return rst_n && en && (!m_full || (m_port ? y1r : y0r));
    endfunction

    always @(posedge clk) begin
        bit rdy_now, take, dlv;
        if (!rst_n) begin
            m_full = 0; m_port = 0; m_mode = 0; m_rr = 0; m_data = 0;
            m_wait = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            rdy_now = model_ready();
            take    = in_valid && rdy_now;
            dlv     = m_full && (m_port ? y1r : y0r);
            if (dlv) begin
                if (m_port) m_cnt1++; else m_cnt0++;
                m_rr   = !m_port;
                m_full = 0;
            end else if (m_full && !m_mode && TIMEOUT != 0) begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_port = !m_port;
                    m_wait = 0;
                end
            end
            if (take) begin
                m_full = 1;
                m_data = in_data;
                m_mode = mode;
                m_port = mode ? in_dest : m_rr;
                m_wait = 0;
            end
        end
        if (y0_valid && y0r) log_q.push_back({1'b0, y0_data});
        if (y1_valid && y1r) log_q.push_back({1'b1, y1_data});
    end

    always @(negedge clk) begin
        bit       e_rdy, e_v0, e_v1, e_sel;
        bit [7:0] e_d0, e_d1;
        int       e_c0, e_c1;
        e_rdy = model_ready();
        e_v0  = rst_n && m_full && !m_port;
        e_v1  = rst_n && m_full &&  m_port;
        e_d0  = e_v0 ? m_data : 8'h00;
        e_d1  = e_v1 ? m_data : 8'h00;
        e_sel = rst_n && m_port;
        e_c0  = rst_n ? m_cnt0 : 0;
        e_c1  = rst_n ? m_cnt1 : 0;
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("y0_valid", 32'(y0_valid), 32'(e_v0));
        chk("y1_valid", 32'(y1_valid), 32'(e_v1));
        chk("y0_data",  32'(y0_data),  32'(e_d0));
        chk("y1_data",  32'(y1_data),  32'(e_d1));
        chk("sel",      32'(sel),      32'(e_sel));
        chk("cnt0",     32'(cnt0),     e_c0 & 32'hFFFF);
        chk("cnt1",     32'(cnt1),     e_c1 & 32'hFFFF);
        chk("w_cnt0",   32'(w_cnt0),   e_c0 & 32'hF);
        chk("w_cnt1",   32'(w_cnt1),   e_c1 & 32'hF);
        chk("w_sel",    32'(w_sel),    32'(e_sel));
        chk("w_in_ready", 32'(w_in_ready), 32'(e_rdy));
        chk("w_valids", 32'({w_y0_valid, w_y1_valid}), 32'({e_v0, e_v1}));
        chk("w_data",   32'({w_y0_data, w_y1_data}), 32'({e_d0, e_d1}));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        log_q.delete();
    endtask

    initial begin
        rst_n = 0; en = 0; mode = 0; in_valid = 0; in_data = 0; in_dest = 0;
        y0r = 1; y1r = 1;
        tick(); tick();
        en = 1;
        tick();
        rst_n = 1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 1);
        chk("rel_sel", 32'(sel), 0);

        // reset while a beat is held
        y0r = 0; y1r = 0; in_valid = 1; in_data = 8'h3C;
        tick();
        in_valid = 0;
        tick();
        chk("hold_y0_valid", 32'(y0_valid), 1);
        rst_n = 0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_valids", 32'({y0_valid, y1_valid}), 0);
        chk("rst_data", 32'({y0_data, y1_data}), 0);
        tick();
        rst_n = 1;
        #1;
        chk("rst_rel_in_ready", 32'(in_ready), 1);
        chk("rst_rel_sel", 32'(sel), 0);
        y0r = 1; y1r = 1;

        // round-robin back-to-back stream
        do_reset();
        mode = 0; in_valid = 1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_data = 8'h44; tick();
        in_valid = 0;
        tick(); tick();
        chk("rr_cnt0", 32'(cnt0), 2);
        chk("rr_cnt1", 32'(cnt1), 2);
        chk("rr_log_n", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("rr_log0", 32'(log_q[0]), 32'h011);
            chk("rr_log1", 32'(log_q[1]), 32'h122);
            chk("rr_log2", 32'(log_q[2]), 32'h033);
            chk("rr_log3", 32'(log_q[3]), 32'h144);
        end

        // steered beat with a long stall: no redirect
        do_reset();
        mode = 1; in_dest = 1; y1r = 0; in_valid = 1; in_data = 8'hA5;
        tick();
        in_valid = 0;
        repeat (40) tick();
        chk("st_y1_valid", 32'(y1_valid), 1);
        chk("st_y1_data", 32'(y1_data), 32'hA5);
        chk("st_sel", 32'(sel), 1);
        chk("st_in_ready", 32'(in_ready), 0);
        y1r = 1;
        tick();
        chk("st_cnt1", 32'(cnt1), 1);
        chk("st_y1_valid_after", 32'(y1_valid), 0);

        // round-robin redirect after TIMEOUT stalled cycles
        do_reset();
        mode = 0; in_dest = 0; y0r = 0; y1r = 1; in_valid = 1; in_data = 8'hC3;
        tick();
        in_valid = 0;
        repeat (14) tick();
        chk("rd_sel_before", 32'(sel), 0);
        tick();
        chk("rd_sel_after", 32'(sel), 1);
        chk("rd_y1_data", 32'({y1_valid, y1_data}), 32'h1C3);
        tick();
        chk("rd_cnt1", 32'(cnt1), 1);
        chk("rd_cnt0", 32'(cnt0), 0);
        y0r = 1;

        // enable gating
        do_reset();
        y0r = 0; y1r = 0; mode = 0; in_valid = 1; in_data = 8'h5A;
        tick();
        en = 0; in_data = 8'h66;
        repeat (3) tick();
        chk("en_in_ready", 32'(in_ready), 0);
        chk("en_held", 32'({y0_valid, y0_data}), 32'h15A);
        y0r = 1;
        tick();
        chk("en_cnt0", 32'(cnt0), 1);
        repeat (3) tick();
        chk("en_valids", 32'({y0_valid, y1_valid}), 0);
        chk("en_cnt_total", 32'(cnt0) + 32'(cnt1), 1);
        in_valid = 0; en = 1; y1r = 1;

        // counter wrap on the 4-bit instance
        do_reset();
        mode = 1; in_dest = 0; in_valid = 1;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'(i + 1);
            tick();
        end
        in_valid = 0;
        tick(); tick();
        chk("wrap_w_cnt0", 32'(w_cnt0), 1);
        chk("wrap_cnt0", 32'(cnt0), 17);

        // mixed traffic, model-checked every cycle
        do_reset();
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            in_dest  = 1'($urandom);
            mode     = 1'($urandom_range(0, 7) == 0) ? ~mode : mode;
            en       = 1'($urandom_range(0, 7) != 0);
            y0r      = 1'($urandom_range(0, 4) == 0);
            y1r      = 1'($urandom_range(0, 2) == 0);
            tick();
        end
        in_valid = 0; y0r = 1; y1r = 1;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
